microondas_timer_ctrl: RTL and testbench

- Parametrised cooking controller, successor to the fixed microwave control FSM.
- Owns the MM:SS countdown, power level, door interlock, pause/resume, quick-start (+30 s), done alarm and magnetron duty cycling.
- Sits between the upstream button edge detectors, which supply single-cycle command pulses, and the display driver and magnetron/lamp outputs.

---
 rtl/microondas_timer_ctrl.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_microondas_timer_ctrl.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/microondas_timer_ctrl.sv
// Microwave cooking controller: MM:SS countdown, power level, door
// interlock, pause/resume, quick start, done alarm, magnetron duty cycle.
//
// Ports:
//   clock, reset      rising-edge clock, async active-low reset
//   start_p .. pwr_dn_p  single-cycle command pulses from button logic
//   door_open         level, 1 = door open
//   field_sel         time field edited by inc_p/dec_p
//                     (0 sec units, 1 sec tens, 2 min units, 3 min tens)
//   minutes, seconds  remaining/programmed time, binary
//   power             power level 1..POWER_LEVELS
//   state             0 IDLE, 1 COOK, 2 PAUSE, 3 DONE
//   heat_on, lamp     magnetron enable and cavity lamp
//   done_beep         alarm, high while in DONE
module microondas_timer_ctrl #(
    parameter  int TICK_DIV     = 100000000,
    parameter  int MAX_MIN      = 99,
    parameter  int POWER_LEVELS = 10,
    parameter  int DONE_SECS    = 3,
    parameter  int QUICK_SECS   = 30,
    localparam int MIN_W        = $clog2(MAX_MIN + 1),
    localparam int PW_W         = $clog2(POWER_LEVELS + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_p,
    input  logic             stop_p,
    input  logic             pause_p,
    input  logic             inc_p,
    input  logic             dec_p,
    input  logic             pwr_up_p,
    input  logic             pwr_dn_p,
    input  logic             door_open,
    input  logic [1:0]       field_sel,
    output logic [MIN_W-1:0] minutes,
    output logic [5:0]       seconds,
    output logic [PW_W-1:0]  power,
    output logic [1:0]       state,
    output logic             heat_on,
    output logic             lamp,
    output logic             done_beep
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_COOK  = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int PS_W = $clog2(TICK_DIV);
    localparam int DC_W = $clog2(DONE_SECS + 1);

    localparam logic [PS_W-1:0] PS_LAST   = PS_W'(TICK_DIV - 1);
    localparam logic [PW_W-1:0] DUTY_LAST = PW_W'(POWER_LEVELS - 1);
    localparam logic [PW_W-1:0] PWR_MAX   = PW_W'(POWER_LEVELS);
    localparam logic [PW_W-1:0] PWR_MIN   = PW_W'(1);
    localparam logic [DC_W-1:0] DONE_LAST = DC_W'(DONE_SECS - 1);

    logic [PS_W-1:0]  prescaler;
    logic [PW_W-1:0]  duty_cnt;
    logic [DC_W-1:0]  done_cnt;

    logic [1:0]       state_n;
    logic [MIN_W-1:0] min_n;
    logic [5:0]       sec_n;
    logic [PW_W-1:0]  pwr_n;
    logic [PS_W-1:0]  ps_n;
    logic [PW_W-1:0]  duty_n;
    logic [DC_W-1:0]  dcnt_n;
    logic             lamp_n;

    logic             tick;
    logic             time_zero;
    logic [PS_W-1:0]  ps_adv;
    logic [PW_W-1:0]  duty_adv;

    // Edited / quick-added / decremented time, computed in int arithmetic
    int               ed_m;
    int               ed_s;
    int               qk_m;
    int               qk_s;
    int               dn_m;
    int               dn_s;
    logic [PW_W-1:0]  pwr_adj;

    assign tick      = (prescaler == PS_LAST);
    assign time_zero = (minutes == '0) && (seconds == '0);
    assign ps_adv    = tick ? '0 : prescaler + 1'b1;
    assign duty_adv  = (duty_cnt == DUTY_LAST) ? '0 : duty_cnt + 1'b1;

    // Time field edit (IDLE only); inc and dec together do nothing
    always_comb begin
        ed_m = int'(minutes);
        ed_s = int'(seconds);
        if (inc_p && !dec_p) begin
            case (field_sel)
                2'd0: begin
                    if (!(ed_m == MAX_MIN && ed_s == 59)) begin
                        if (ed_s == 59) begin
                            ed_s = 0;
                            ed_m = ed_m + 1;
                        end else begin
                            ed_s = ed_s + 1;
                        end
                    end
                end
                2'd1: begin
                    if (ed_m != MAX_MIN) begin
                        ed_s = ed_s + 10;
                        if (ed_s >= 60) begin
                            ed_s = ed_s - 60;
                            ed_m = ed_m + 1;
                        end
                    end
                end
                2'd2: begin
                    if (ed_m < MAX_MIN) ed_m = ed_m + 1;
                end
                default: begin
                    ed_m = (ed_m + 10 > MAX_MIN) ? MAX_MIN : ed_m + 10;
                end
            endcase
        end else if (dec_p && !inc_p) begin
            case (field_sel)
                2'd0: begin
                    if (!(ed_m == 0 && ed_s == 0)) begin
                        if (ed_s == 0) begin
                            ed_s = 59;
                            ed_m = ed_m - 1;
                        end else begin
                            ed_s = ed_s - 1;
                        end
                    end
                end
                2'd1: begin
                    if (ed_s >= 10) begin
                        ed_s = ed_s - 10;
                    end else if (ed_m > 0) begin
                        ed_m = ed_m - 1;
                        ed_s = ed_s + 50;
                    end
                end
                2'd2: begin
                    if (ed_m > 0) ed_m = ed_m - 1;
                end
                default: begin
                    ed_m = (ed_m < 10) ? 0 : ed_m - 10;
                end
            endcase
        end
    end

    // Quick add with carry; overflow past MAX_MIN saturates at MAX_MIN:59
    always_comb begin
        qk_m = int'(minutes);
        qk_s = int'(seconds) + QUICK_SECS;
        if (qk_s >= 60) begin
            qk_s = qk_s - 60;
            qk_m = qk_m + 1;
        end
        if (qk_m > MAX_MIN) begin
            qk_m = MAX_MIN;
            qk_s = 59;
        end
    end

    // One-second countdown step
    always_comb begin
        dn_m = int'(minutes);
        dn_s = int'(seconds);
        if (dn_s > 0) begin
            dn_s = dn_s - 1;
        end else if (dn_m > 0) begin
            dn_m = dn_m - 1;
            dn_s = 59;
        end
    end

    // Power adjust, saturating; both buttons together do nothing
    always_comb begin
        pwr_adj = power;
        if (pwr_up_p && !pwr_dn_p && power < PWR_MAX)
            pwr_adj = power + 1'b1;
        else if (pwr_dn_p && !pwr_up_p && power > PWR_MIN)
            pwr_adj = power - 1'b1;
    end

    always_comb begin
        state_n = state;
        min_n   = minutes;
        sec_n   = seconds;
        pwr_n   = power;
        ps_n    = prescaler;
        duty_n  = duty_cnt;
        dcnt_n  = done_cnt;
        case (state)
            S_IDLE: begin
                ps_n   = '0;
                duty_n = '0;
                dcnt_n = '0;
                pwr_n  = pwr_adj;
                if (stop_p) begin
                    min_n = '0;
                    sec_n = '0;
                end else if (start_p && !door_open) begin
                    state_n = S_COOK;
                    if (time_zero) sec_n = 6'(QUICK_SECS);
                end else if (!start_p) begin
                    min_n = MIN_W'(ed_m);
                    sec_n = 6'(ed_s);
                end
            end
            S_COOK: begin
                if (stop_p) begin
                    state_n = S_IDLE;
                    min_n   = '0;
                    sec_n   = '0;
                end else if (door_open || pause_p) begin
                    // Prescaler and duty held so the partial second survives
                    state_n = S_PAUSE;
                end else begin
                    ps_n = ps_adv;
                    if (tick) duty_n = duty_adv;
                    if (start_p) begin
                        min_n = MIN_W'(qk_m);
                        sec_n = 6'(qk_s);
                    end else if (tick) begin
                        min_n = MIN_W'(dn_m);
                        sec_n = 6'(dn_s);
                        if (dn_m == 0 && dn_s == 0) begin
                            state_n = S_DONE;
                            dcnt_n  = '0;
                        end
                    end
                end
            end
            S_PAUSE: begin
                pwr_n = pwr_adj;
                if (stop_p) begin
                    state_n = S_IDLE;
                    min_n   = '0;
                    sec_n   = '0;
                end else if ((pause_p || start_p) && !door_open) begin
                    state_n = S_COOK;
                end
            end
            default: begin
                if (stop_p || door_open) begin
                    state_n = S_IDLE;
                    ps_n    = '0;
                end else begin
                    ps_n = ps_adv;
                    if (tick) begin
                        if (done_cnt == DONE_LAST) begin
                            state_n = S_IDLE;
                        end else begin
                            dcnt_n = done_cnt + 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    assign lamp_n = door_open || (state_n == S_COOK);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            minutes   <= '0;
            seconds   <= '0;
            power     <= PWR_MAX;
            prescaler <= '0;
            duty_cnt  <= '0;
            done_cnt  <= '0;
            lamp      <= 1'b0;
        end else begin
            state     <= state_n;
            minutes   <= min_n;
            seconds   <= sec_n;
            power     <= pwr_n;
            prescaler <= ps_n;
            duty_cnt  <= duty_n;
            done_cnt  <= dcnt_n;
            lamp      <= lamp_n;
        end
    end

    // An open door always forces COOK -> PAUSE on the sampling edge,
    // so decoding registered state alone keeps heat off with the door open.
    assign heat_on   = (state == S_COOK) && (duty_cnt < power);
    assign done_beep = (state == S_DONE);

endmodule

// File: tb/tb_microondas_timer_ctrl.sv
// Directed testbench for microondas_timer_ctrl with TICK_DIV=4.
// Inputs driven on falling edges, outputs sampled on falling edges.
module tb_microondas_timer_ctrl;

    logic       clock;
    logic       reset;
    logic       start_p;
    logic       stop_p;
    logic       pause_p;
    logic       inc_p;
    logic       dec_p;
    logic       pwr_up_p;
    logic       pwr_dn_p;
    logic       door_open;
    logic [1:0] field_sel;
    logic [6:0] minutes;
    logic [5:0] seconds;
    logic [3:0] power;
    logic [1:0] state;
    logic       heat_on;
    logic       lamp;
    logic       done_beep;

    int checks;
    int errors;

    localparam logic [6:0] C_START = 7'b1000000;
    localparam logic [6:0] C_STOP  = 7'b0100000;
    localparam logic [6:0] C_PAUSE = 7'b0010000;
    localparam logic [6:0] C_INC   = 7'b0001000;
    localparam logic [6:0] C_DEC   = 7'b0000100;
    localparam logic [6:0] C_UP    = 7'b0000010;
    localparam logic [6:0] C_DN    = 7'b0000001;

    microondas_timer_ctrl #(
        .TICK_DIV    (4),
        .MAX_MIN     (99),
        .POWER_LEVELS(10),
        .DONE_SECS   (3),
        .QUICK_SECS  (30)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start_p  (start_p),
        .stop_p   (stop_p),
        .pause_p  (pause_p),
        .inc_p    (inc_p),
        .dec_p    (dec_p),
        .pwr_up_p (pwr_up_p),
        .pwr_dn_p (pwr_dn_p),
        .door_open(door_open),
        .field_sel(field_sel),
        .minutes  (minutes),
        .seconds  (seconds),
        .power    (power),
        .state    (state),
        .heat_on  (heat_on),
        .lamp     (lamp),
        .done_beep(done_beep)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic cmd(input logic [6:0] c);
        {start_p, stop_p, pause_p, inc_p, dec_p, pwr_up_p, pwr_dn_p} = c;
        @(negedge clock);
        {start_p, stop_p, pause_p, inc_p, dec_p, pwr_up_p, pwr_dn_p} = '0;
    endtask

    // Clear to 0:00 in IDLE, then enter seconds first, minutes last
    task automatic set_time(input int m, input int s);
        cmd(C_STOP);
        field_sel = 2'd1;
        repeat (s / 10) cmd(C_INC);
        field_sel = 2'd0;
        repeat (s % 10) cmd(C_INC);
        field_sel = 2'd3;
        repeat (m / 10) cmd(C_INC);
        field_sel = 2'd2;
        repeat (m % 10) cmd(C_INC);
    endtask

    task automatic test_reset();
        checks++;
        if (state !== 2'd0 || minutes !== 7'd0 || seconds !== 6'd0) begin
            errors++;
            $display("FAIL reset_time st=%0d %0d:%0d exp 0 0:0",
                     state, minutes, seconds);
        end
        checks++;
        if (power !== 4'd10 || heat_on !== 1'b0 || lamp !== 1'b0 ||
            done_beep !== 1'b0) begin
            errors++;
            $display("FAIL reset_out pwr=%0d heat=%0d lamp=%0d beep=%0d exp 10 0 0 0",
                     power, heat_on, lamp, done_beep);
        end
    endtask

    task automatic test_countdown();
        int cnt;
        int guard;
        set_time(0, 3);
        checks++;
        if (seconds !== 6'd3) begin
            errors++;
            $display("FAIL cd_setup got %0d exp 3", seconds);
        end
        cmd(C_START);
        checks++;
        if (state !== 2'd1 || heat_on !== 1'b1 || lamp !== 1'b1) begin
            errors++;
            $display("FAIL cd_cook st=%0d heat=%0d lamp=%0d exp 1 1 1",
                     state, heat_on, lamp);
        end
        step(3);
        checks++;
        if (seconds !== 6'd3) begin
            errors++;
            $display("FAIL cd_before_tick got %0d exp 3", seconds);
        end
        step(1);
        checks++;
        if (seconds !== 6'd2) begin
            errors++;
            $display("FAIL cd_tick1 got %0d exp 2", seconds);
        end
        step(4);
        checks++;
        if (seconds !== 6'd1) begin
            errors++;
            $display("FAIL cd_tick2 got %0d exp 1", seconds);
        end
        step(4);
        checks++;
        if (seconds !== 6'd0 || state !== 2'd3 || done_beep !== 1'b1 ||
            heat_on !== 1'b0) begin
            errors++;
            $display("FAIL cd_done sec=%0d st=%0d beep=%0d heat=%0d exp 0 3 1 0",
                     seconds, state, done_beep, heat_on);
        end
        cnt = 0;
        guard = 0;
        while (done_beep === 1'b1 && guard < 40) begin
            cnt++;
            guard++;
            step(1);
        end
        checks++;
        if (cnt != 12 || state !== 2'd0) begin
            errors++;
            $display("FAIL cd_beep_len got %0d st=%0d exp 12 0", cnt, state);
        end
    endtask

    task automatic test_quick_start();
        cmd(C_STOP);
        door_open = 1'b1;
        cmd(C_START);
        checks++;
        if (state !== 2'd0 || seconds !== 6'd0) begin
            errors++;
            $display("FAIL qs_door_open st=%0d sec=%0d exp 0 0", state, seconds);
        end
        door_open = 1'b0;
        step(1);
        cmd(C_START);
        checks++;
        if (state !== 2'd1 || minutes !== 7'd0 || seconds !== 6'd30) begin
            errors++;
            $display("FAIL qs_load st=%0d %0d:%0d exp 1 0:30",
                     state, minutes, seconds);
        end
        step(20);
        checks++;
        if (seconds !== 6'd25) begin
            errors++;
            $display("FAIL qs_count got %0d exp 25", seconds);
        end
        cmd(C_START);
        checks++;
        if (minutes !== 7'd0 || seconds !== 6'd55 || state !== 2'd1) begin
            errors++;
            $display("FAIL qs_add got %0d:%0d st=%0d exp 0:55 1",
                     minutes, seconds, state);
        end
        cmd(C_STOP);
        checks++;
        if (state !== 2'd0 || seconds !== 6'd0 || minutes !== 7'd0) begin
            errors++;
            $display("FAIL qs_stop st=%0d %0d:%0d exp 0 0:0",
                     state, minutes, seconds);
        end
        set_time(99, 50);
        cmd(C_START);
        cmd(C_START);
        checks++;
        if (minutes !== 7'd99 || seconds !== 6'd59) begin
            errors++;
            $display("FAIL qs_saturate got %0d:%0d exp 99:59", minutes, seconds);
        end
        cmd(C_STOP);
    endtask

    task automatic test_edit();
        set_time(0, 55);
        field_sel = 2'd1;
        cmd(C_INC);
        checks++;
        if (minutes !== 7'd1 || seconds !== 6'd5) begin
            errors++;
            $display("FAIL ed_tens_inc got %0d:%0d exp 1:5", minutes, seconds);
        end
        cmd(C_DEC);
        checks++;
        if (minutes !== 7'd0 || seconds !== 6'd55) begin
            errors++;
            $display("FAIL ed_tens_dec got %0d:%0d exp 0:55", minutes, seconds);
        end
        set_time(0, 5);
        field_sel = 2'd1;
        cmd(C_DEC);
        checks++;
        if (minutes !== 7'd0 || seconds !== 6'd5) begin
            errors++;
            $display("FAIL ed_tens_floor got %0d:%0d exp 0:5", minutes, seconds);
        end
        set_time(95, 0);
        field_sel = 2'd3;
        cmd(C_INC);
        checks++;
        if (minutes !== 7'd99) begin
            errors++;
            $display("FAIL ed_min10_clamp got %0d exp 99", minutes);
        end
        set_time(3, 0);
        field_sel = 2'd3;
        cmd(C_DEC);
        checks++;
        if (minutes !== 7'd0) begin
            errors++;
            $display("FAIL ed_min10_floor got %0d exp 0", minutes);
        end
        field_sel = 2'd0;
        cmd(C_DEC);
        checks++;
        if (minutes !== 7'd0 || seconds !== 6'd0) begin
            errors++;
            $display("FAIL ed_zero_dec got %0d:%0d exp 0:0", minutes, seconds);
        end
        set_time(99, 59);
        field_sel = 2'd0;
        cmd(C_INC);
        checks++;
        if (minutes !== 7'd99 || seconds !== 6'd59) begin
            errors++;
            $display("FAIL ed_max_inc got %0d:%0d exp 99:59", minutes, seconds);
        end
        set_time(0, 59);
        field_sel = 2'd0;
        cmd(C_INC);
        checks++;
        if (minutes !== 7'd1 || seconds !== 6'd0) begin
            errors++;
            $display("FAIL ed_units_carry got %0d:%0d exp 1:0", minutes, seconds);
        end
        field_sel = 2'd0;
        {inc_p, dec_p} = 2'b11;
        step(1);
        {inc_p, dec_p} = 2'b00;
        checks++;
        if (minutes !== 7'd1 || seconds !== 6'd0) begin
            errors++;
            $display("FAIL ed_both got %0d:%0d exp 1:0", minutes, seconds);
        end
        cmd(C_STOP);
    endtask

    task automatic test_door_pause();
        set_time(2, 0);
        cmd(C_START);
        step(2);
        door_open = 1'b1;
        step(1);
        checks++;
        if (state !== 2'd2 || heat_on !== 1'b0 || lamp !== 1'b1) begin
            errors++;
            $display("FAIL dp_pause st=%0d heat=%0d lamp=%0d exp 2 0 1",
                     state, heat_on, lamp);
        end
        step(9);
        checks++;
        if (minutes !== 7'd2 || seconds !== 6'd0 || state !== 2'd2 ||
            heat_on !== 1'b0) begin
            errors++;
            $display("FAIL dp_frozen %0d:%0d st=%0d heat=%0d exp 2:0 2 0",
                     minutes, seconds, state, heat_on);
        end
        door_open = 1'b0;
        step(1);
        cmd(C_PAUSE);
        checks++;
        if (state !== 2'd1 || minutes !== 7'd2 || seconds !== 6'd0) begin
            errors++;
            $display("FAIL dp_resume st=%0d %0d:%0d exp 1 2:0",
                     state, minutes, seconds);
        end
        step(1);
        checks++;
        if (minutes !== 7'd2 || seconds !== 6'd0) begin
            errors++;
            $display("FAIL dp_partial_hold got %0d:%0d exp 2:0", minutes, seconds);
        end
        step(1);
        checks++;
        if (minutes !== 7'd1 || seconds !== 6'd59) begin
            errors++;
            $display("FAIL dp_partial_tick got %0d:%0d exp 1:59", minutes, seconds);
        end
        cmd(C_STOP);
    endtask

    task automatic test_power_duty();
        int on_secs;
        logic exp_heat;
        repeat (7) cmd(C_DN);
        checks++;
        if (power !== 4'd3) begin
            errors++;
            $display("FAIL pw_set got %0d exp 3", power);
        end
        set_time(0, 20);
        cmd(C_START);
        on_secs = 0;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) step(4);
            exp_heat = ((k % 10) < 3);
            checks++;
            if (heat_on !== exp_heat) begin
                errors++;
                $display("FAIL pw_duty_s%0d got %0d exp %0d", k, heat_on, exp_heat);
            end
            if (heat_on === 1'b1) on_secs++;
        end
        checks++;
        if (on_secs != 6 || seconds !== 6'd1) begin
            errors++;
            $display("FAIL pw_on_secs got %0d sec=%0d exp 6 1", on_secs, seconds);
        end
        cmd(C_UP);
        checks++;
        if (power !== 4'd3) begin
            errors++;
            $display("FAIL pw_cook_ignored got %0d exp 3", power);
        end
        cmd(C_PAUSE);
        cmd(C_UP);
        checks++;
        if (power !== 4'd4 || state !== 2'd2) begin
            errors++;
            $display("FAIL pw_pause_up got %0d st=%0d exp 4 2", power, state);
        end
        cmd(C_STOP);
    endtask

    task automatic test_stop_priority();
        set_time(1, 0);
        cmd(C_START);
        step(2);
        cmd(C_STOP | C_PAUSE);
        checks++;
        if (state !== 2'd0 || minutes !== 7'd0 || seconds !== 6'd0 ||
            heat_on !== 1'b0) begin
            errors++;
            $display("FAIL sp_stop_pause st=%0d %0d:%0d heat=%0d exp 0 0:0 0",
                     state, minutes, seconds, heat_on);
        end
    endtask

    task automatic test_async_reset();
        repeat (6) cmd(C_UP);
        set_time(1, 0);
        cmd(C_START);
        step(2);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (heat_on !== 1'b0 || state !== 2'd0 || minutes !== 7'd0 ||
            lamp !== 1'b0 || power !== 4'd10) begin
            errors++;
            $display("FAIL ar_async heat=%0d st=%0d min=%0d lamp=%0d pwr=%0d exp 0 0 0 0 10",
                     heat_on, state, minutes, lamp, power);
        end
        @(negedge clock);
        reset = 1'b1;
        step(1);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        door_open = 1'b0;
        field_sel = 2'd0;
        {start_p, stop_p, pause_p, inc_p, dec_p, pwr_up_p, pwr_dn_p} = '0;
        step(2);
        test_reset();
        reset = 1'b1;
        step(1);
        test_countdown();
        test_quick_start();
        test_edit();
        test_door_pause();
        test_power_duty();
        test_stop_priority();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, errors);
        $finish;
    end

endmodule
